// File: rtl/seven_seg_scanner.sv
// Purpose : time-multiplexed DIGITS-wide hex 7-segment scanner with per-digit blank slot.
// Latency : load lands in shadow at the sampling edge; a lit slot shows it from that edge on.
// Backpr. : none; load is accepted every cycle, and holding it high reloads each edge.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; forces outputs inactive immediately
//   value        packed hex digits, digit i = value[4i+3:4i]
//   load         1 at an edge copies value into the shadow register
//   digitSelect  one-hot digit enable (bit i = digit i)
//   segments     {A,B,C,D,E,F,G}, A = MSB
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a digit i > 0 is dark in its lit slot if it and all higher
//   digits of the shadow value are zero. Digit 0 is always shown.

module seven_seg_scanner #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic [DIGITS-1:0]     digitSelect,
  output logic [6:0]            segments
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // The slot phase is fully determined by div_cnt; the enum names it so the
  // output logic reads as a two-state scan machine.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_LIT   = 1'b1
  } scan_state_t;

  logic [4*DIGITS-1:0] shadow;
  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       digit_idx;

  scan_state_t         scan_st;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   sel_onehot;
  logic                digit_on;
  logic [DIGITS-1:0]   sel_act;
  logic [6:0]          seg_act;
`ifdef LEADING_ZERO_BLANK_EN
  logic                upper_zero;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1110011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // State registers: shadow value, slot divider and digit pointer.
  // Load and digit advance are independent, so both land on a shared edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Outputs depend only on the registers above, never on value/load directly.
  always_comb begin
    scan_st    = (div_cnt == '0) ? ST_BLANK : ST_LIT;
    cur_nib    = 4'h0;
    sel_onehot = '0;
    digit_on   = 1'b1;
    sel_act    = '0;
    seg_act    = '0;

    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_nib       = shadow[4*i +: 4];
        sel_onehot[i] = 1'b1;
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; upper_zero stays set while every digit
    // seen so far (this one included) is zero.
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (shadow[4*i +: 4] == 4'h0);
      if ((digit_idx == IW'(i)) && upper_zero) begin
        digit_on = 1'b0;
      end
    end
`endif

    if ((scan_st == ST_LIT) && digit_on) begin
      sel_act = sel_onehot;
      seg_act = hex_to_seg(cur_nib);
    end
  end

  // Polarity is applied last so the inactive level inverts too.
  assign digitSelect = sel_act ^ {DIGITS{ACTIVE_LOW}};
  assign segments    = seg_act ^ {7{ACTIVE_LOW}};

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Purpose : checks seven_seg_scanner (DIGITS=4, DIV=4) in both polarities against a
//           time-based reference model: slot = t mod DIV, digit = (t div DIV) mod DIGITS.
// Latency : the model advances one step per clock edge; outputs are sampled 1 time unit after it.

module tb_seven_seg_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  sel, sel_al;
  logic [6:0]  seg, seg_al;

  int          errors = 0;
  int          checks = 0;

  // Reference model state: edges since reset release, plus the loaded value.
  int          t_m;
  logic [15:0] shadow_m;
  logic [6:0]  dec_m [16];

  logic [3:0]  tsel [4];
  logic [6:0]  tseg [4];

  seven_seg_scanner #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .digitSelect(sel), .segments(seg)
  );

  seven_seg_scanner #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .digitSelect(sel_al), .segments(seg_al)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t_m, $time);
    end
  endtask

  task automatic model_expect(output logic [3:0] es, output logic [6:0] eg);
    int          slot;
    int          d;
    logic [15:0] upper;
    logic        lit;
    slot  = t_m % DIV;
    d     = (t_m / DIV) % DIGITS;
    upper = shadow_m >> (4 * d);
    lit   = (slot != 0);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0) lit = 1'b0;
`endif
    es = 4'h0;
    eg = 7'h0;
    if (lit) begin
      es = 4'(1 << d);
      eg = dec_m[upper[3:0]];
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] es, es_n;
    logic [6:0] eg, eg_n;
    model_expect(es, eg);
    es_n = ~es;
    eg_n = ~eg;
    check({tag, "_sel"},    sel,    es);
    check({tag, "_seg"},    seg,    eg);
    check({tag, "_sel_al"}, sel_al, es_n);
    check({tag, "_seg_al"}, seg_al, eg_n);
  endtask

  // Called just after an edge; the new inputs are seen at the next edge.
  task automatic step(input logic ld, input logic [15:0] v, input string tag);
    load  = ld;
    value = v;
    @(posedge clk);
    if (reset) begin
      t_m      = 0;
      shadow_m = 16'h0;
    end else begin
      if (ld) shadow_m = v;
      t_m++;
    end
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset with no edge, then held across one edge, then released.
  task automatic pulse_reset(input string tag);
    load  = 1'b0;
    reset = 1'b1;
    #1;
    check({tag, "_async_sel"},    sel,    32'h0);
    check({tag, "_async_seg"},    seg,    32'h0);
    check({tag, "_async_sel_al"}, sel_al, 32'hF);
    check({tag, "_async_seg_al"}, seg_al, 32'h7F);
    t_m      = 0;
    shadow_m = 16'h0;
    @(posedge clk);
    #1;
    compare_all({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    dec_m = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    t_m      = 0;
    shadow_m = 16'h0;

    #12;
    check("por_sel",    sel,    32'h0);
    check("por_seg",    seg,    32'h0);
    check("por_sel_al", sel_al, 32'hF);
    check("por_seg_al", seg_al, 32'h7F);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // One full scan of 16'h1234, checked at the first lit cycle of each slot.
    tsel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tseg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    step(1'b1, 16'h1234, "scan");
    check("scan_s0_sel", sel, 32'(tsel[0]));
    check("scan_s0_seg", seg, 32'(tseg[0]));
    for (int k = 2; k <= 17; k++) begin
      step(1'b0, 16'h0, "scan");
      if (t_m % DIV == 1 && t_m < 16) begin
        check("scan_slot_sel", sel, 32'(tsel[t_m / DIV]));
        check("scan_slot_seg", seg, 32'(tseg[t_m / DIV]));
      end
    end
    // Wrap: t=17 here is the 18th cycle after reset, digit 0 lit again.
    check("wrap_sel", sel, 32'h1);
    check("wrap_seg", seg, 32'h33);

    // Mid-slot load during digit 0 lit cycle 2 shows in lit cycle 3.
    step(1'b0, 16'h0, "pre_mid");
    step(1'b1, 16'h000F, "mid");
    check("mid_sel", sel, 32'h1);
    check("mid_seg", seg, 32'h47);

    // Reset mid-LIT, then first edge after release lights digit 0.
    pulse_reset("rst");
    step(1'b0, 16'h0, "rel");
    check("rel_sel", sel, 32'h1);

    // Low-active view of 16'h0008.
    step(1'b1, 16'h0008, "al");
    check("al_lit_sel", sel_al, 32'hE);
    check("al_lit_seg", seg_al, 32'h00);
    step(1'b0, 16'h0, "al");
    step(1'b0, 16'h0, "al");
    check("al_blank_sel", sel_al, 32'hF);
    check("al_blank_seg", seg_al, 32'h7F);

    // Leading-zero behaviour for 16'h0050 and 16'h0000.
`ifdef LEADING_ZERO_BLANK_EN
    tsel = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
    tseg = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
`else
    tsel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tseg = '{7'b1111110, 7'b1011011, 7'b1111110, 7'b1111110};
`endif
    pulse_reset("lz");
    step(1'b1, 16'h0050, "lz");
    for (int k = 0; k < 15; k++) begin
      if (t_m % DIV == 1) begin
        check("lz50_sel", sel, 32'(tsel[t_m / DIV]));
        check("lz50_seg", seg, 32'(tseg[t_m / DIV]));
      end
      step(1'b0, 16'h0, "lz");
    end
    pulse_reset("lz0");
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 16'h0, "lz0");
      if (t_m == 1) check("lz0_d0_sel", sel, 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
      if (t_m > DIV) check("lz0_dark_sel", sel, 32'h0);
`endif
    end

    // Randomized traffic: sparse reloads, bursts of held load, values with
    // random leading-zero runs, and occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      int          r;
      logic [15:0] v;
      r = int'($urandom_range(0, 99));
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if (r < 2) pulse_reset("rnd_rst");
      else       step(r < 30, v, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
